// File: rtl/qnigma_crc_pkg.sv
// Shared constants, byte-update function and FSM state type for the
// qnigma Ethernet CRC-32 engine.
package qnigma_crc_pkg;

    localparam logic [31:0] CRC32_POLY_REFL = 32'hEDB88320;
    localparam logic [31:0] CRC32_INIT      = 32'hFFFFFFFF;
    localparam logic [31:0] CRC32_RESIDUE   = 32'hDEBB20E3;

    typedef enum logic {
        IDLE,
        ACTIVE
    } crc_state_t;

    function automatic logic [31:0] crc32_byte(
        input logic [31:0] crc,
        input logic [7:0]  data
    );
        logic [31:0] c;
        c = crc ^ {24'h0, data};
        for (int i = 0; i < 8; i++) begin
            if (c[0]) c = (c >> 1) ^ CRC32_POLY_REFL;
            else      c = c >> 1;
        end
        return c;
    endfunction

endpackage

// File: rtl/qnigma_crc32_unroll.sv
// Combinational W_BYTES-deep CRC-32 byte chain; the result is tapped
// after the last kept lane (keep 0 or above W_BYTES selects all lanes).
module qnigma_crc32_unroll
    import qnigma_crc_pkg::*;
#(
    parameter int W_BYTES = 4,
    parameter int KW      = $clog2(W_BYTES) + 1
) (
    input  logic [31:0]          crc_in,
    input  logic [8*W_BYTES-1:0] dat,
    input  logic [KW-1:0]        keep,
    output logic [31:0]          crc_out
);

    logic [31:0] stage [W_BYTES+1];
    int          lanes;

    assign stage[0] = crc_in;

    for (genvar i = 0; i < W_BYTES; i++) begin : g_stage
        assign stage[i+1] = crc32_byte(stage[i], dat[8*i +: 8]);
    end

    assign lanes = (keep == '0 || int'(keep) > W_BYTES) ? W_BYTES : int'(keep);

    always_comb begin
        crc_out = stage[W_BYTES];
        for (int i = 1; i <= W_BYTES; i++) begin
            if (lanes == i) crc_out = stage[i];
        end
    end

endmodule

// File: rtl/qnigma_crc32_stream.sv
// Frame-aware multi-byte Ethernet CRC-32 engine with FCS and residue check.
// Optional saturating bad-frame counter: define QNIGMA_CRC_ERRCNT_EN.
module qnigma_crc32_stream
    import qnigma_crc_pkg::*;
#(
    parameter int W_BYTES = 4,
    parameter int KW      = $clog2(W_BYTES) + 1
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [8*W_BYTES-1:0] in_dat,
    input  logic                 in_val,
    input  logic                 in_sof,
    input  logic                 in_eof,
    input  logic [KW-1:0]        in_keep,
    output logic                 res_val,
    output logic [31:0]          res_crc,
    output logic                 res_ok,
    output logic                 res_abort,
    output logic                 busy
`ifdef QNIGMA_CRC_ERRCNT_EN
    ,
    output logic [15:0]          err_cnt
`endif
);

    if (W_BYTES != 1 && W_BYTES != 2 && W_BYTES != 4 && W_BYTES != 8) begin : g_bad_w
        $error("qnigma_crc32_stream: W_BYTES must be 1, 2, 4 or 8");
    end

    crc_state_t  state, state_nxt;
    logic [31:0] crc, crc_nxt;
    logic [31:0] upd_in, upd_out;
    logic [KW-1:0] upd_keep;
    logic        rep, rep_abort, rep_ok;
    logic [31:0] rep_raw;

    // A SOF beat always restarts from init; keep only matters on EOF beats
    assign upd_in   = in_sof ? CRC32_INIT : crc;
    assign upd_keep = in_eof ? in_keep : '0;

    qnigma_crc32_unroll #(
        .W_BYTES (W_BYTES),
        .KW      (KW)
    ) u_unroll (
        .crc_in  (upd_in),
        .dat     (in_dat),
        .keep    (upd_keep),
        .crc_out (upd_out)
    );

    always_comb begin
        state_nxt = state;
        crc_nxt   = crc;
        rep       = 1'b0;
        rep_abort = 1'b0;
        rep_raw   = upd_out;
        unique case (state)
            IDLE: begin
                if (in_val && in_sof) begin
                    if (in_eof) begin
                        rep     = 1'b1;
                        crc_nxt = CRC32_INIT;
                    end else begin
                        state_nxt = ACTIVE;
                        crc_nxt   = upd_out;
                    end
                end
            end
            ACTIVE: begin
                if (in_val) begin
                    if (in_sof) begin
                        // Old frame is reported as aborted; its CRC excludes this beat
                        rep       = 1'b1;
                        rep_abort = 1'b1;
                        rep_raw   = crc;
                        if (in_eof) begin
                            state_nxt = IDLE;
                            crc_nxt   = CRC32_INIT;
                        end else begin
                            crc_nxt = upd_out;
                        end
                    end else if (in_eof) begin
                        rep       = 1'b1;
                        state_nxt = IDLE;
                        crc_nxt   = CRC32_INIT;
                    end else begin
                        crc_nxt = upd_out;
                    end
                end
            end
            default: begin
                state_nxt = IDLE;
                crc_nxt   = CRC32_INIT;
            end
        endcase
    end

    assign rep_ok = !rep_abort && (rep_raw == CRC32_RESIDUE);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= IDLE;
            crc   <= CRC32_INIT;
        end else begin
            state <= state_nxt;
            crc   <= crc_nxt;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            res_val   <= 1'b0;
            res_crc   <= '0;
            res_ok    <= 1'b0;
            res_abort <= 1'b0;
        end else begin
            res_val <= rep;
            if (rep) begin
                res_crc   <= ~rep_raw;
                res_ok    <= rep_ok;
                res_abort <= rep_abort;
            end
        end
    end

    assign busy = (state == ACTIVE);

`ifdef QNIGMA_CRC_ERRCNT_EN
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            err_cnt <= '0;
        end else if (rep && !rep_ok && err_cnt != 16'hFFFF) begin
            err_cnt <= err_cnt + 16'd1;
        end
    end
`endif

endmodule

// File: tb/tb_qnigma_crc32_stream.sv
// Randomized self-checking bench for qnigma_crc32_stream (W_BYTES 4 and 1)
// against a bit-serial CRC reference over whole frames.
module tb_qnigma_crc32_stream;

    typedef byte unsigned bq_t[$];

    logic        clk = 1'b0;
    logic        rst = 1'b0;

    logic [31:0] d4 = '0;
    logic        v4 = 1'b0, s4 = 1'b0, e4 = 1'b0;
    logic [2:0]  k4 = '0;
    logic        rv4, ro4, ra4, bz4;
    logic [31:0] rc4;

    logic [7:0]  d1 = '0;
    logic        v1 = 1'b0, s1 = 1'b0, e1 = 1'b0;
    logic [0:0]  k1 = '0;
    logic        rv1, ro1, ra1, bz1;
    logic [31:0] rc1;

`ifdef QNIGMA_CRC_ERRCNT_EN
    logic [15:0] ec4, ec1;
`endif

    int n_cmp = 0;
    int n_err = 0;
    int rv4_cnt = 0;
    int rv1_cnt = 0;
    bit bz4_seen = 1'b0;

    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (rv4 === 1'b1) rv4_cnt++;
        if (rv1 === 1'b1) rv1_cnt++;
        if (bz4 === 1'b1) bz4_seen = 1'b1;
    end

    qnigma_crc32_stream #(.W_BYTES(4)) u4 (
        .clk       (clk),
        .rst       (rst),
        .in_dat    (d4),
        .in_val    (v4),
        .in_sof    (s4),
        .in_eof    (e4),
        .in_keep   (k4),
        .res_val   (rv4),
        .res_crc   (rc4),
        .res_ok    (ro4),
        .res_abort (ra4),
        .busy      (bz4)
`ifdef QNIGMA_CRC_ERRCNT_EN
        ,
        .err_cnt   (ec4)
`endif
    );

    qnigma_crc32_stream #(.W_BYTES(1)) u1 (
        .clk       (clk),
        .rst       (rst),
        .in_dat    (d1),
        .in_val    (v1),
        .in_sof    (s1),
        .in_eof    (e1),
        .in_keep   (k1),
        .res_val   (rv1),
        .res_crc   (rc1),
        .res_ok    (ro1),
        .res_abort (ra1),
        .busy      (bz1)
`ifdef QNIGMA_CRC_ERRCNT_EN
        ,
        .err_cnt   (ec1)
`endif
    );

    // Bit-serial LFSR over the whole frame, wire order: byte by byte, LSB first
    function automatic logic [31:0] ref_crc(input bq_t q);
        logic [31:0] c;
        logic        fb;
        c = 32'hFFFFFFFF;
        foreach (q[i]) begin
            for (int b = 0; b < 8; b++) begin
                fb = c[0] ^ q[i][b];
                c  = c >> 1;
                if (fb) c = c ^ 32'hEDB88320;
            end
        end
        return c;
    endfunction

    function automatic bq_t str2q(input string s);
        bq_t q;
        for (int i = 0; i < s.len(); i++) q.push_back(s[i]);
        return q;
    endfunction

    function automatic bq_t add_fcs(input bq_t q);
        bq_t r;
        logic [31:0] f;
        r = q;
        f = ~ref_crc(q);
        r.push_back(f[7:0]);
        r.push_back(f[15:8]);
        r.push_back(f[23:16]);
        r.push_back(f[31:24]);
        return r;
    endfunction

    function automatic bq_t rand_q(input int n);
        bq_t q;
        for (int i = 0; i < n; i++) q.push_back(8'($urandom));
        return q;
    endfunction

    function automatic logic [31:0] pack4(input bq_t q, input int off);
        logic [31:0] d;
        for (int l = 0; l < 4; l++) d[8*l +: 8] = q[off+l];
        return d;
    endfunction

    task automatic beat4(input logic [31:0] d, input logic v, input logic s,
                         input logic e, input logic [2:0] k);
        d4 = d; v4 = v; s4 = s; e4 = e; k4 = k;
        @(posedge clk);
        #1;
    endtask

    task automatic idle4(input int n);
        repeat (n) beat4($urandom, 1'b0, 1'($urandom), 1'($urandom), 3'($urandom));
    endtask

    task automatic beat1(input logic [7:0] d, input logic v, input logic s,
                         input logic e, input logic k);
        d1 = d; v1 = v; s1 = s; e1 = e; k1 = k;
        @(posedge clk);
        #1;
    endtask

    task automatic send4(input bq_t q, input bit gaps);
        int n;
        int nb;
        n  = q.size();
        nb = (n + 3) / 4;
        for (int b = 0; b < nb; b++) begin
            logic [31:0] d;
            logic [2:0]  k;
            int          rem;
            if (gaps) while ($urandom_range(0, 2) == 0) idle4(1);
            d   = $urandom;
            rem = n - 4 * b;
            if (rem > 4) rem = 4;
            for (int l = 0; l < rem; l++) d[8*l +: 8] = q[4*b+l];
            k = 3'($urandom);
            if (b == nb - 1) begin
                if (rem < 4) k = 3'(rem);
                else if ($urandom_range(0, 3) == 0) k = 3'd0;
                else k = 3'($urandom_range(4, 7));
            end
            beat4(d, 1'b1, b == 0, b == nb - 1, k);
        end
        v4 = 1'b0;
    endtask

    task automatic send1(input bq_t q, input bit gaps);
        for (int b = 0; b < q.size(); b++) begin
            if (gaps) while ($urandom_range(0, 1) == 0) begin
                beat1(8'($urandom), 1'b0, 1'($urandom), 1'($urandom), 1'($urandom));
            end
            beat1(q[b], 1'b1, b == 0, b == q.size() - 1, 1'($urandom));
        end
        v1 = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        if ({rv4, ro4, ra4, bz4, rc4} !== 36'h0) begin
            $display("FAIL reset_w4: got %b%b%b%b %h want 0000 00000000", rv4, ro4, ra4, bz4, rc4);
            n_err++;
        end
        n_cmp++;
        if ({rv1, ro1, ra1, bz1, rc1} !== 36'h0) begin
            $display("FAIL reset_w1: got %b%b%b%b %h want 0000 00000000", rv1, ro1, ra1, bz1, rc1);
            n_err++;
        end
        n_cmp++;
`ifdef QNIGMA_CRC_ERRCNT_EN
        if ({ec4, ec1} !== 32'h0) begin
            $display("FAIL reset_errcnt: got %h %h want 0", ec4, ec1);
            n_err++;
        end
        n_cmp++;
`endif
        rst = 1'b1;
        idle4(2);
    endtask

    task automatic test_known();
        bq_t q;
        int  c;
        q = str2q("123456789");
        send4(q, 1'b0);
        c = rv4_cnt;
        if (rv4 !== 1'b1 || rc4 !== 32'hCBF43926 || ro4 !== 1'b0 || ra4 !== 1'b0) begin
            $display("FAIL known_vec: got v%b %h ok%b ab%b want v1 cbf43926 ok0 ab0", rv4, rc4, ro4, ra4);
            n_err++;
        end
        n_cmp++;
        idle4(1);
        if (rv4 !== 1'b0 || rv4_cnt != c + 1 || rc4 !== ~ref_crc(q)) begin
            $display("FAIL known_pulse: got v%b cnt%0d %h want v0 cnt%0d %h", rv4, rv4_cnt, rc4, c + 1, ~ref_crc(q));
            n_err++;
        end
        n_cmp++;
    endtask

    task automatic test_fcs_good();
        bq_t q;
        q = add_fcs(str2q("123456789"));
        send4(q, 1'b0);
        if (rv4 !== 1'b1 || ro4 !== 1'b1 || ra4 !== 1'b0 || rc4 !== ~ref_crc(q)) begin
            $display("FAIL fcs_good: got v%b ok%b ab%b %h want v1 ok1 ab0 %h", rv4, ro4, ra4, rc4, ~ref_crc(q));
            n_err++;
        end
        n_cmp++;
        idle4(1);
    endtask

    task automatic test_w1_gaps();
        bq_t q;
        q = str2q("123456789");
        for (int r = 0; r < 3; r++) begin
            send1(q, 1'b1);
            if (rv1 !== 1'b1 || rc1 !== 32'hCBF43926 || ro1 !== 1'b0 || ra1 !== 1'b0) begin
                $display("FAIL w1_gaps: got v%b %h ok%b ab%b want v1 cbf43926 ok0 ab0", rv1, rc1, ro1, ra1);
                n_err++;
            end
            n_cmp++;
            beat1(8'h0, 1'b0, 1'b0, 1'b0, 1'b0);
        end
        for (int r = 0; r < 6; r++) begin
            q = rand_q($urandom_range(1, 10));
            if (r[0]) q = add_fcs(q);
            send1(q, 1'b1);
            if (rv1 !== 1'b1 || rc1 !== ~ref_crc(q) || ro1 !== (ref_crc(q) == 32'hDEBB20E3)) begin
                $display("FAIL w1_rand: got v%b %h ok%b want v1 %h ok%b", rv1, rc1, ro1, ~ref_crc(q), ref_crc(q) == 32'hDEBB20E3);
                n_err++;
            end
            n_cmp++;
            beat1(8'h0, 1'b0, 1'b0, 1'b0, 1'b0);
        end
    endtask

    task automatic test_single();
        bq_t q;
        q = str2q("1234");
        bz4_seen = 1'b0;
        beat4(pack4(q, 0), 1'b1, 1'b1, 1'b1, 3'd0);
        v4 = 1'b0;
        if (rv4 !== 1'b1 || rc4 !== 32'h9BE3E0A3 || rc4 !== ~ref_crc(q)) begin
            $display("FAIL single_beat: got v%b %h want v1 9be3e0a3", rv4, rc4);
            n_err++;
        end
        n_cmp++;
        idle4(2);
        if (bz4_seen !== 1'b0 || bz4 !== 1'b0) begin
            $display("FAIL single_busy: got seen%b busy%b want 0 0", bz4_seen, bz4);
            n_err++;
        end
        n_cmp++;
    endtask

    task automatic test_abort();
        bq_t q1, q2;
        q1 = rand_q(8);
        q2 = str2q("123456789");
        beat4(pack4(q1, 0), 1'b1, 1'b1, 1'b0, 3'($urandom));
        beat4(pack4(q1, 4), 1'b1, 1'b0, 1'b0, 3'($urandom));
        if (bz4 !== 1'b1 || rv4 !== 1'b0) begin
            $display("FAIL abort_open: got busy%b v%b want busy1 v0", bz4, rv4);
            n_err++;
        end
        n_cmp++;
        beat4(pack4(q2, 0), 1'b1, 1'b1, 1'b0, 3'($urandom));
        if (rv4 !== 1'b1 || ra4 !== 1'b1 || ro4 !== 1'b0 || rc4 !== ~ref_crc(q1) || bz4 !== 1'b1) begin
            $display("FAIL abort_pulse: got v%b ab%b ok%b %h busy%b want v1 ab1 ok0 %h busy1", rv4, ra4, ro4, rc4, bz4, ~ref_crc(q1));
            n_err++;
        end
        n_cmp++;
        beat4(pack4(q2, 4), 1'b1, 1'b0, 1'b0, 3'($urandom));
        if (rv4 !== 1'b0) begin
            $display("FAIL abort_mid: got v%b want v0", rv4);
            n_err++;
        end
        n_cmp++;
        beat4({24'($urandom), 8'h39}, 1'b1, 1'b0, 1'b1, 3'd1);
        v4 = 1'b0;
        if (rv4 !== 1'b1 || ra4 !== 1'b0 || rc4 !== 32'hCBF43926) begin
            $display("FAIL abort_new: got v%b ab%b %h want v1 ab0 cbf43926", rv4, ra4, rc4);
            n_err++;
        end
        n_cmp++;
        idle4(1);
    endtask

    task automatic test_abort_eof();
        bq_t q1;
        int  c;
        q1 = rand_q(4);
        beat4(pack4(q1, 0), 1'b1, 1'b1, 1'b0, 3'($urandom));
        beat4($urandom, 1'b1, 1'b1, 1'b1, 3'd0);
        v4 = 1'b0;
        c = rv4_cnt;
        if (rv4 !== 1'b1 || ra4 !== 1'b1 || ro4 !== 1'b0 || rc4 !== ~ref_crc(q1)) begin
            $display("FAIL abort_eof: got v%b ab%b ok%b %h want v1 ab1 ok0 %h", rv4, ra4, ro4, rc4, ~ref_crc(q1));
            n_err++;
        end
        n_cmp++;
        idle4(2);
        if (rv4_cnt != c + 1 || bz4 !== 1'b0 || rc4 !== ~ref_crc(q1)) begin
            $display("FAIL abort_eof_after: got cnt%0d busy%b %h want cnt%0d busy0 %h", rv4_cnt, bz4, rc4, c + 1, ~ref_crc(q1));
            n_err++;
        end
        n_cmp++;
    endtask

    task automatic test_idle_drop();
        bq_t q;
        int  c;
        c = rv4_cnt;
        beat4($urandom, 1'b1, 1'b0, 1'b0, 3'($urandom));
        beat4($urandom, 1'b1, 1'b0, 1'b1, 3'($urandom));
        beat4($urandom, 1'b1, 1'b0, 1'b1, 3'd0);
        v4 = 1'b0;
        idle4(1);
        if (rv4_cnt != c || bz4 !== 1'b0) begin
            $display("FAIL idle_drop: got cnt%0d busy%b want cnt%0d busy0", rv4_cnt, bz4, c);
            n_err++;
        end
        n_cmp++;
        q = rand_q(11);
        send4(q, 1'b0);
        if (rv4 !== 1'b1 || rc4 !== ~ref_crc(q)) begin
            $display("FAIL idle_after: got v%b %h want v1 %h", rv4, rc4, ~ref_crc(q));
            n_err++;
        end
        n_cmp++;
        idle4(1);
    endtask

    task automatic test_back_to_back();
        bq_t qa, qb;
        int  c;
        qa = rand_q($urandom_range(5, 16));
        qb = add_fcs(rand_q($urandom_range(5, 16)));
        send4(qa, 1'b0);
        c = rv4_cnt;
        if (rv4 !== 1'b1 || rc4 !== ~ref_crc(qa) || ro4 !== 1'b0) begin
            $display("FAIL b2b_a: got v%b %h ok%b want v1 %h ok0", rv4, rc4, ro4, ~ref_crc(qa));
            n_err++;
        end
        n_cmp++;
        send4(qb, 1'b0);
        if (rv4 !== 1'b1 || rc4 !== ~ref_crc(qb) || ro4 !== 1'b1 || rv4_cnt != c + 1) begin
            $display("FAIL b2b_b: got v%b %h ok%b cnt%0d want v1 %h ok1 cnt%0d", rv4, rc4, ro4, rv4_cnt, ~ref_crc(qb), c + 1);
            n_err++;
        end
        n_cmp++;
        idle4(1);
    endtask

    task automatic test_random();
        bq_t q;
        logic [31:0] exp_crc;
        logic        exp_ok;
        for (int r = 0; r < 30; r++) begin
            q = rand_q($urandom_range(1, 24));
            if ($urandom_range(0, 1) == 1) q = add_fcs(q);
            exp_crc = ~ref_crc(q);
            exp_ok  = (ref_crc(q) == 32'hDEBB20E3);
            send4(q, 1'b1);
            if (rv4 !== 1'b1 || rc4 !== exp_crc || ro4 !== exp_ok || ra4 !== 1'b0) begin
                $display("FAIL rand_w4 #%0d len%0d: got v%b %h ok%b ab%b want v1 %h ok%b ab0", r, q.size(), rv4, rc4, ro4, ra4, exp_crc, exp_ok);
                n_err++;
            end
            n_cmp++;
            idle4($urandom_range(0, 2));
        end
    endtask

    task automatic test_hold();
        bq_t q;
        q = add_fcs(rand_q(7));
        send4(q, 1'b0);
        idle4(3);
        if (rv4 !== 1'b0 || rc4 !== ~ref_crc(q) || ro4 !== 1'b1 || ra4 !== 1'b0) begin
            $display("FAIL hold: got v%b %h ok%b ab%b want v0 %h ok1 ab0", rv4, rc4, ro4, ra4, ~ref_crc(q));
            n_err++;
        end
        n_cmp++;
    endtask

    task automatic test_reset_mid();
        bq_t q;
        int  c;
        q = rand_q(12);
        beat4(pack4(q, 0), 1'b1, 1'b1, 1'b0, 3'($urandom));
        beat4(pack4(q, 4), 1'b1, 1'b0, 1'b0, 3'($urandom));
        c = rv4_cnt;
        #2;
        rst = 1'b0;
        v4  = 1'b0;
        #1;
        if ({rv4, ro4, ra4, bz4, rc4} !== 36'h0) begin
            $display("FAIL reset_mid: got %b%b%b%b %h want 0000 00000000", rv4, ro4, ra4, bz4, rc4);
            n_err++;
        end
        n_cmp++;
        @(posedge clk);
        #1;
        rst = 1'b1;
        idle4(2);
        if (rv4_cnt != c) begin
            $display("FAIL reset_mid_noval: got cnt%0d want %0d", rv4_cnt, c);
            n_err++;
        end
        n_cmp++;
        send4(q, 1'b0);
        if (rv4 !== 1'b1 || rc4 !== ~ref_crc(q)) begin
            $display("FAIL reset_mid_after: got v%b %h want v1 %h", rv4, rc4, ~ref_crc(q));
            n_err++;
        end
        n_cmp++;
        idle4(1);
    endtask

`ifdef QNIGMA_CRC_ERRCNT_EN
    task automatic test_errcnt();
        bq_t qa, qb, qc, qd;
        rst = 1'b0;
        #1;
        rst = 1'b1;
        idle4(1);
        qa = rand_q(8);
        qb = rand_q(9);
        qc = rand_q(6);
        qd = add_fcs(rand_q(10));
        beat4(pack4(qa, 0), 1'b1, 1'b1, 1'b0, 3'd0);
        beat4(pack4(qa, 4), 1'b1, 1'b0, 1'b0, 3'd0);
        send4(qb, 1'b0);
        send4(qc, 1'b1);
        send4(qd, 1'b1);
        if (ec4 !== 16'd3) begin
            $display("FAIL errcnt_3: got %0d want 3", ec4);
            n_err++;
        end
        n_cmp++;
        for (int i = 0; i < 65540; i++) begin
            beat4($urandom, 1'b1, 1'b1, 1'b1, 3'd0);
        end
        v4 = 1'b0;
        idle4(1);
        if (ec4 !== 16'hFFFF) begin
            $display("FAIL errcnt_sat: got %h want ffff", ec4);
            n_err++;
        end
        n_cmp++;
        beat4(pack4(qa, 0), 1'b1, 1'b1, 1'b1, 3'd0);
        v4 = 1'b0;
        idle4(1);
        if (ec4 !== 16'hFFFF) begin
            $display("FAIL errcnt_hold: got %h want ffff", ec4);
            n_err++;
        end
        n_cmp++;
        beat4(pack4(qa, 0), 1'b1, 1'b1, 1'b0, 3'd0);
        #2;
        rst = 1'b0;
        v4  = 1'b0;
        #1;
        if ({ec4, rv4, ro4, ra4, bz4, rc4} !== 52'h0) begin
            $display("FAIL errcnt_rst: got %h %b%b%b%b %h want 0", ec4, rv4, ro4, ra4, bz4, rc4);
            n_err++;
        end
        n_cmp++;
        @(posedge clk);
        #1;
        rst = 1'b1;
        idle4(1);
    endtask
`endif

    initial begin
        test_reset();
        test_known();
        test_fcs_good();
        test_w1_gaps();
        test_single();
        test_abort();
        test_abort_eof();
        test_idle_drop();
        test_back_to_back();
        test_random();
        test_hold();
        test_reset_mid();
`ifdef QNIGMA_CRC_ERRCNT_EN
        test_errcnt();
`endif
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
